prog_sequencer: RTL and testbench

- Program sequencer placed between the instruction ROM (1-cycle synchronous read) and the processor control FSM.
- Replaces the free-running ROM address counter.
- Fetches each instruction word and, for mvi, prefetches its immediate word. Pulses run, presents the words on the processor Din bus at the cycles the FSM samples them, then waits for Done.
- Advances a program counter, handles halt, and supports single-step.

---
 rtl/prog_sequencer.sv | 143 ++++++++++++++
 tb/tb_prog_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_sequencer.sv
// Program sequencer between the instruction ROM and the processor control FSM.
// Optional watchdog on WAIT_DONE is enabled with `define PROG_SEQ_WDOG_EN.
module prog_sequencer #(
  parameter int          ADDR_W  = 5,
  parameter int          DATA_W  = 9,
  parameter logic [2:0]  OP_MVI  = 3'b001,
  parameter logic [2:0]  OP_HALT = 3'b111
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step_mode,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] proc_din,
  output logic              proc_run,
  input  logic              proc_done,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              err_timeout
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_PREF   = 3'd3;
  localparam logic [2:0] S_ISSUE  = 3'd4;
  localparam logic [2:0] S_WAIT   = 3'd5;
  localparam logic [2:0] S_HALTED = 3'd6;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] imm_q;
  logic              skip_q;
  logic              wd_expire;
  logic [2:0]        ir_op;
  logic [2:0]        rd_op;
  logic [ADDR_W-1:0] pc_inc1;
  logic [ADDR_W-1:0] pc_inc2;

  assign ir_op   = ir_q[DATA_W-1 -: 3];
  assign rd_op   = rom_data[DATA_W-1 -: 3];
  assign pc_inc1 = pc + ADDR_W'(1);
  assign pc_inc2 = pc + ADDR_W'(2);

  assign rom_addr = (state == S_DECODE) ? pc_inc1 : pc;
  assign proc_run = (state == S_ISSUE);
  assign busy     = (state != S_IDLE) && (state != S_HALTED);
  assign halted   = (state == S_HALTED);

`ifdef PROG_SEQ_WDOG_EN
  logic [3:0] wd_cnt;
  logic       err_q;

  // Expiry fires on the cycle the count would step to 15, i.e. the 15th WAIT_DONE cycle.
  assign wd_expire   = (state == S_WAIT) && !proc_done && (wd_cnt == 4'd14);
  assign err_timeout = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == S_ISSUE)
        wd_cnt <= '0;
      else if ((state == S_WAIT) && !proc_done)
        wd_cnt <= wd_cnt + 4'd1;
      if (wd_expire)
        err_q <= 1'b1;
    end
  end
`else
  assign wd_expire   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: state_nxt = (rd_op == OP_HALT) ? S_HALTED : S_PREF;
      S_PREF:   state_nxt = S_ISSUE;
      S_ISSUE:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (proc_done) begin
          if (halt_req)       state_nxt = S_HALTED;
          else if (step_mode) state_nxt = S_IDLE;
          else                state_nxt = S_FETCH;
        end else if (wd_expire) begin
          state_nxt = S_HALTED;
        end
      end
      S_HALTED: if (start && !halt_req) state_nxt = S_FETCH;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      pc       <= '0;
      proc_din <= '0;
      ir_q     <= '0;
      imm_q    <= '0;
      skip_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_DECODE: begin
          ir_q <= rom_data;
          if (rd_op == OP_HALT)
            skip_q <= 1'b1;
        end
        S_PREF: begin
          imm_q    <= rom_data;
          proc_din <= ir_q;
        end
        S_ISSUE: begin
          if (ir_op == OP_MVI) begin
            proc_din <= imm_q;
            pc       <= pc_inc2;
          end else begin
            pc <= pc_inc1;
          end
        end
        S_HALTED: begin
          // pc stays on a halt word while parked; it is stepped past only on resume.
          if (state_nxt == S_FETCH) begin
            skip_q <= 1'b0;
            if (skip_q)
              pc <= pc_inc1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench for prog_sequencer: a driver walks the program with a
// high-level interpreter and queues expected events; a monitor checks them.
module tb_prog_sequencer;
  localparam int AW = 5;
  localparam int DW = 9;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_HALT = 3'b111;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          step_mode;
  logic          halt_req;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] proc_din;
  logic          proc_run;
  logic          proc_done;
  logic [AW-1:0] pc;
  logic          busy;
  logic          halted;
  logic          err_timeout;

  logic [DW-1:0] rom [32];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    bit            is_halt;
    logic [DW-1:0] word;
    logic [DW-1:0] imm;
    logic [AW-1:0] pc_after;
    int            at;
  } ev_t;
  ev_t sb[$];

  prog_sequencer #(.ADDR_W(AW), .DATA_W(DW), .OP_MVI(OP_MVI), .OP_HALT(OP_HALT)) dut (
    .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .halt_req(halt_req),
    .rom_addr(rom_addr), .rom_data(rom_data), .proc_din(proc_din), .proc_run(proc_run),
    .proc_done(proc_done), .pc(pc), .busy(busy), .halted(halted), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_data <= rom[rom_addr];
    cyc      <= cyc + 1;
  end

  function automatic ev_t mk(input bit h, input logic [DW-1:0] w, input logic [DW-1:0] imm,
                             input logic [AW-1:0] pa, input int at);
    ev_t e;
    e.is_halt = h; e.word = w; e.imm = imm; e.pc_after = pa; e.at = at;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting for DUT (cycle %0d)", name, cyc);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_rom_addr"}, rom_addr, 0);
    check({tag, "_pc"}, pc, 0);
    check({tag, "_proc_din"}, proc_din, 0);
    check({tag, "_proc_run"}, proc_run, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_halted"}, halted, 0);
    check({tag, "_err"}, err_timeout, 0);
  endtask

  // Monitor: pops an expected event whenever the DUT issues or parks.
  initial begin : monitor
    bit  pend;
    bit  hprev;
    ev_t cur;
    pend  = 1'b0;
    hprev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend  = 1'b0;
        hprev = 1'b0;
        continue;
      end
      if (pend) begin
        pend = 1'b0;
        check("pc_after_issue", pc, cur.pc_after);
        check("din_t1", proc_din, (cur.word[DW-1 -: 3] == OP_MVI) ? cur.imm : cur.word);
        check("run_width", proc_run, 0);
      end else if (proc_run) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_run: got run with din %0h expected no run (cycle %0d)", proc_din, cyc);
        end else begin
          cur = sb.pop_front();
          check("run_kind_is_halt", cur.is_halt, 0);
          check("run_cycle", cyc, cur.at);
          check("din_t0", proc_din, cur.word);
          check("busy_run", busy, 1);
          pend = !cur.is_halt;
        end
      end
      if (halted && !hprev) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_halt: got halted at pc %0h expected none (cycle %0d)", pc, cyc);
        end else begin
          cur = sb.pop_front();
          check("halt_kind_is_halt", cur.is_halt, 1);
          check("halt_cycle", cyc, cur.at);
          check("halt_pc", pc, cur.pc_after);
          check("busy_halted", busy, 0);
        end
      end
      hprev = halted;
    end
  end

  task automatic resume(input bit skip, inout logic [AW-1:0] m_pc, output int c);
    if ($urandom_range(1) == 1) begin
      halt_req = 1'b1;
      start    = 1'b1;
      repeat (2) begin
        @(negedge clk);
        check("halt_hold", halted, 1);
      end
    end
    halt_req = 1'b0;
    start    = 1'b1;
    c        = cyc;
    if (skip) m_pc = m_pc + 5'd1;
  endtask

  // Interprets the program from pc=0 for n instructions, randomizing control inputs.
  task automatic run_prog(input int n, inout bit abort);
    int            c, d, k, wn;
    logic [AW-1:0] m_pc, nxt, pa;
    logic [DW-1:0] w;
    bit            hreq, stp, mvi;
    m_pc  = '0;
    start = 1'b1;
    c     = cyc;
    for (int i = 0; i < n; i++) begin
      w   = rom[m_pc];
      nxt = m_pc + 5'd1;
      if (w[DW-1 -: 3] == OP_HALT) begin
        sb.push_back(mk(1'b1, w, '0, m_pc, c + 3));
        @(negedge clk); start = 1'b0; proc_done = 1'b0;
        wn = 0;
        while (!halted && wn < 10) begin @(negedge clk); wn++; end
        if (!halted) begin timeout_fail("halt_op_wait"); abort = 1'b1; return; end
        resume(1'b1, m_pc, c);
      end else begin
        mvi = (w[DW-1 -: 3] == OP_MVI);
        pa  = mvi ? m_pc + 5'd2 : nxt;
        sb.push_back(mk(1'b0, w, rom[nxt], pa, c + 4));
        @(negedge clk); start = 1'b0; proc_done = 1'b0;
        wn = 0;
        while (!proc_run && wn < 10) begin @(negedge clk); wn++; end
        if (!proc_run) begin timeout_fail("run_wait"); abort = 1'b1; return; end
        m_pc = pa;
        hreq = ($urandom_range(5) == 0);
        stp  = ($urandom_range(3) == 0);
        k    = $urandom_range(1, 4);
        halt_req  = hreq;
        step_mode = stp;
        start     = stp;
        repeat (k) @(negedge clk);
        proc_done = 1'b1;
        d = cyc;
        if (hreq) begin
          sb.push_back(mk(1'b1, '0, '0, m_pc, d + 1));
          @(negedge clk); proc_done = 1'b0;
          wn = 0;
          while (!halted && wn < 10) begin @(negedge clk); wn++; end
          if (!halted) begin timeout_fail("halt_req_wait"); abort = 1'b1; return; end
          resume(1'b0, m_pc, c);
        end else if (stp) begin
          @(negedge clk); proc_done = 1'b0;
          c = cyc;
        end else begin
          c = d;
        end
      end
    end
  endtask

  task automatic end_phase();
    #2 rst = 1'b1;
    start = 1'b0; step_mode = 1'b0; halt_req = 1'b0; proc_done = 1'b0;
    check("sb_empty", sb.size(), 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin : driver
    bit abort;
    int wn, r;
    abort = 1'b0;
    rst = 1'b0; start = 1'b0; step_mode = 1'b0; halt_req = 1'b0; proc_done = 1'b0;
    for (int i = 0; i < 32; i++) rom[i] = {3'b010, 6'($urandom)};
    rom[0] = 9'b001000000;
    rom[1] = 9'd5;
    rom[2] = 9'b111000000;
    rom[3] = 9'b000001000;
    rom[4] = 9'b010001010;
    rom[5] = 9'b010010011;
    rom[6] = 9'b111000000;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;
    @(negedge clk);
    run_prog(7, abort);
    end_phase();

    if (!abort) begin
      for (int i = 0; i < 32; i++) rom[i] = 9'($urandom);
      rom[30] = {3'b010, 6'($urandom)};
      rom[31] = {OP_MVI, 6'($urandom)};
      rom[0]  = 9'd7;
      run_prog(90, abort);
      check("err_clear_default", err_timeout, 0);
      end_phase();
    end

    rom[0] = 9'b000001000;
    rom[1] = 9'b010000001;
`ifdef PROG_SEQ_WDOG_EN
    if (!abort) begin
      start = 1'b1;
      sb.push_back(mk(1'b0, rom[0], rom[1], 5'd1, cyc + 4));
      @(negedge clk); start = 1'b0;
      wn = 0;
      while (!proc_run && wn < 10) begin @(negedge clk); wn++; end
      if (!proc_run) timeout_fail("wdog_run_wait");
      r = cyc;
      sb.push_back(mk(1'b1, '0, '0, 5'd1, r + 16));
      wn = 0;
      while (!halted && wn < 30) begin @(negedge clk); wn++; end
      if (!halted) timeout_fail("wdog_halt_wait");
      check("wdog_err", err_timeout, 1);
      check("wdog_halted", halted, 1);
      end_phase();
    end
`endif

    if (!abort) begin
      start = 1'b1;
      sb.push_back(mk(1'b0, rom[0], rom[1], 5'd1, cyc + 4));
      @(negedge clk); start = 1'b0;
      wn = 0;
      while (!proc_run && wn < 10) begin @(negedge clk); wn++; end
      if (!proc_run) timeout_fail("midrst_run_wait");
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check_cleared("midrst");
      check("midrst_sb_empty", sb.size(), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : global_guard
    #2000000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

endmodule
